// File: rtl/game_sequencer.sv
// Match-level controller for the air hockey game: sequences serve/play/goal/pause/over
// phases, keeps both scores and gates the puck/paddle datapath.
module game_sequencer #(
   parameter int WIN_SCORE    = 7,
   parameter int SERVE_FRAMES = 60,
   parameter int GOAL_FRAMES  = 120
) (
   input  logic       InputClock,
   input  logic       rst,
   input  logic       frame_tick,
   input  logic       start_pulse,
   input  logic       pause_pulse,
   input  logic       goal_p1,
   input  logic       goal_p2,
   output logic [2:0] state,
   output logic       play_en,
   output logic       puck_reset,
   output logic       serve_dir,
   output logic [3:0] score_p1,
   output logic [3:0] score_p2,
   output logic [1:0] winner
);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_SERVE = 3'd1;
   localparam logic [2:0] ST_PLAY  = 3'd2;
   localparam logic [2:0] ST_GOAL  = 3'd3;
   localparam logic [2:0] ST_PAUSE = 3'd4;
   localparam logic [2:0] ST_OVER  = 3'd5;

   localparam logic [3:0] WIN_Q      = 4'(WIN_SCORE);
   localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);
   localparam logic [7:0] GOAL_LAST  = 8'(GOAL_FRAMES - 1);

   logic [2:0] state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [3:0] score_p1_q, score_p1_d;
   logic [3:0] score_p2_q, score_p2_d;
   logic       serve_dir_q, serve_dir_d;
   logic [1:0] winner_q, winner_d;
   logic       play_en_q, play_en_d;
   logic       puck_reset_q, puck_reset_d;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      score_p1_d  = score_p1_q;
      score_p2_d  = score_p2_q;
      serve_dir_d = serve_dir_q;
      winner_d    = winner_q;
      case (state_q)
         ST_IDLE: begin
            if (start_pulse) begin
               state_d = ST_SERVE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SERVE: begin
            if (frame_tick && (cnt_q == SERVE_LAST)) begin
               state_d = ST_PLAY;
            end else if (frame_tick) begin
               cnt_d = cnt_q + 8'd1;
            end else begin
               cnt_d = cnt_q;
            end
         end
         ST_PLAY: begin
            // A simultaneous double goal is treated as a replay with no score change.
            if (goal_p1 && goal_p2) begin
               state_d = ST_SERVE;
            end else if (goal_p1) begin
               if (score_p1_q < WIN_Q) begin
                  score_p1_d = score_p1_q + 4'd1;
               end else begin
                  score_p1_d = score_p1_q;
               end
               serve_dir_d = 1'b1;
               state_d     = ST_GOAL;
            end else if (goal_p2) begin
               if (score_p2_q < WIN_Q) begin
                  score_p2_d = score_p2_q + 4'd1;
               end else begin
                  score_p2_d = score_p2_q;
               end
               serve_dir_d = 1'b0;
               state_d     = ST_GOAL;
            end else if (pause_pulse) begin
               state_d = ST_PAUSE;
            end else begin
               state_d = ST_PLAY;
            end
         end
         ST_PAUSE: begin
            if (pause_pulse) begin
               state_d = ST_PLAY;
            end else begin
               state_d = ST_PAUSE;
            end
         end
         ST_GOAL: begin
            if (frame_tick && (cnt_q == GOAL_LAST)) begin
               if (score_p1_q == WIN_Q) begin
                  winner_d = 2'd1;
                  state_d  = ST_OVER;
               end else if (score_p2_q == WIN_Q) begin
                  winner_d = 2'd2;
                  state_d  = ST_OVER;
               end else begin
                  state_d = ST_SERVE;
               end
            end else if (frame_tick) begin
               cnt_d = cnt_q + 8'd1;
            end else begin
               cnt_d = cnt_q;
            end
         end
         ST_OVER: begin
            if (start_pulse) begin
               score_p1_d  = 4'd0;
               score_p2_d  = 4'd0;
               winner_d    = 2'd0;
               serve_dir_d = 1'b0;
               state_d     = ST_SERVE;
            end else begin
               state_d = ST_OVER;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      // Every phase change restarts the frame count, so an entry tick is never counted.
      if (state_d != state_q) begin
         cnt_d = 8'd0;
      end else begin
         cnt_d = cnt_d;
      end
      play_en_d    = (state_d == ST_PLAY);
      puck_reset_d = (state_d == ST_IDLE) || (state_d == ST_SERVE);
   end

   always_ff @(posedge InputClock) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         cnt_q        <= 8'd0;
         score_p1_q   <= 4'd0;
         score_p2_q   <= 4'd0;
         serve_dir_q  <= 1'b0;
         winner_q     <= 2'd0;
         play_en_q    <= 1'b0;
         puck_reset_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         score_p1_q   <= score_p1_d;
         score_p2_q   <= score_p2_d;
         serve_dir_q  <= serve_dir_d;
         winner_q     <= winner_d;
         play_en_q    <= play_en_d;
         puck_reset_q <= puck_reset_d;
      end
   end

   assign state      = state_q;
   assign play_en    = play_en_q;
   assign puck_reset = puck_reset_q;
   assign serve_dir  = serve_dir_q;
   assign score_p1   = score_p1_q;
   assign score_p2   = score_p2_q;
   assign winner     = winner_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Scoreboard bench for game_sequencer: a phase-level reference model predicts every
// cycle's outputs, and a monitor compares them against the DUT one step after each edge.
module tb_game_sequencer;

   localparam int W  = 2;
   localparam int SF = 2;
   localparam int GF = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       frame_tick = 1'b0, start_pulse = 1'b0, pause_pulse = 1'b0;
   logic       goal_p1 = 1'b0, goal_p2 = 1'b0;
   logic [2:0] state;
   logic       play_en, puck_reset, serve_dir;
   logic [3:0] score_p1, score_p2;
   logic [1:0] winner;

   game_sequencer #(.WIN_SCORE(W), .SERVE_FRAMES(SF), .GOAL_FRAMES(GF)) dut (
      .InputClock(clk), .rst(rst), .frame_tick(frame_tick), .start_pulse(start_pulse),
      .pause_pulse(pause_pulse), .goal_p1(goal_p1), .goal_p2(goal_p2), .state(state),
      .play_en(play_en), .puck_reset(puck_reset), .serve_dir(serve_dir),
      .score_p1(score_p1), .score_p2(score_p2), .winner(winner)
   );

   always #5 clk = ~clk;

   typedef struct {
      int st; int pe; int pr; int sd; int s1; int s2; int w;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   bit   stim_done = 1'b0;

   // Reference model: phase name plus ticks remaining before the phase ends.
   string m_phase = "IDLE";
   int    m_left = 0, m_s1 = 0, m_s2 = 0, m_dir = 0, m_win = 0;

   function automatic int phase_code(string p);
      case (p)
         "IDLE":  return 0;
         "SERVE": return 1;
         "PLAY":  return 2;
         "GOAL":  return 3;
         "PAUSE": return 4;
         default: return 5;
      endcase
   endfunction

   task automatic enter(string p);
      m_phase = p;
      if (p == "SERVE") m_left = SF;
      else if (p == "GOAL") m_left = GF;
      else m_left = 0;
   endtask

   task automatic model_step(bit r, bit st, bit pa, bit g1, bit g2, bit tk);
      if (r) begin
         m_phase = "IDLE"; m_left = 0; m_s1 = 0; m_s2 = 0; m_dir = 0; m_win = 0;
      end else if (m_phase == "IDLE") begin
         if (st) enter("SERVE");
      end else if (m_phase == "SERVE") begin
         if (tk) begin
            m_left--;
            if (m_left == 0) enter("PLAY");
         end
      end else if (m_phase == "PLAY") begin
         if (g1 && g2) enter("SERVE");
         else if (g1) begin m_s1 = (m_s1 + 1 > W) ? W : m_s1 + 1; m_dir = 1; enter("GOAL"); end
         else if (g2) begin m_s2 = (m_s2 + 1 > W) ? W : m_s2 + 1; m_dir = 0; enter("GOAL"); end
         else if (pa) enter("PAUSE");
      end else if (m_phase == "PAUSE") begin
         if (pa) enter("PLAY");
      end else if (m_phase == "GOAL") begin
         if (tk) begin
            m_left--;
            if (m_left == 0) begin
               if (m_s1 == W) begin m_win = 1; enter("OVER"); end
               else if (m_s2 == W) begin m_win = 2; enter("OVER"); end
               else enter("SERVE");
            end
         end
      end else begin
         if (st) begin m_s1 = 0; m_s2 = 0; m_win = 0; m_dir = 0; enter("SERVE"); end
      end
   endtask

   task automatic cyc(bit r, bit st, bit pa, bit g1, bit g2, bit tk);
      exp_t e;
      @(negedge clk);
      rst = r; start_pulse = st; pause_pulse = pa; goal_p1 = g1; goal_p2 = g2; frame_tick = tk;
      model_step(r, st, pa, g1, g2, tk);
      e.st = phase_code(m_phase);
      e.pe = (m_phase == "PLAY") ? 1 : 0;
      e.pr = (m_phase == "IDLE" || m_phase == "SERVE") ? 1 : 0;
      e.sd = m_dir; e.s1 = m_s1; e.s2 = m_s2; e.w = m_win;
      exp_q.push_back(e);
   endtask

   task automatic chk(string name, int act, int expv);
      checks++;
      if (act != expv) begin
         errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, expv);
      end
   endtask

   task automatic tick_n(int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 1);
   endtask

   // Directed spot checks of absolute values, taken after the edge that follows the last cyc.
   task automatic spot(string name, int act_sel, int expv);
      @(posedge clk); #2;
      case (act_sel)
         0: chk(name, int'(state), expv);
         1: chk(name, int'(score_p1), expv);
         2: chk(name, int'(score_p2), expv);
         3: chk(name, int'(winner), expv);
         4: chk(name, int'(play_en), expv);
         default: chk(name, int'(puck_reset), expv);
      endcase
   endtask

   // Monitor: pop the prediction for each edge and compare every output.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk); #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("state", int'(state), e.st);
            chk("play_en", int'(play_en), e.pe);
            chk("puck_reset", int'(puck_reset), e.pr);
            chk("serve_dir", int'(serve_dir), e.sd);
            chk("score_p1", int'(score_p1), e.s1);
            chk("score_p2", int'(score_p2), e.s2);
            chk("winner", int'(winner), e.w);
            chk("exclusive_en", int'(play_en & puck_reset), 0);
         end
      end
   end

   // Stimulus: directed walk through the match, then randomized traffic.
   initial begin
      cyc(1, 0, 0, 0, 0, 0); cyc(1, 0, 0, 0, 0, 0);
      spot("reset_state", 0, 0);
      cyc(0, 1, 0, 0, 0, 0);
      spot("serve_entry", 0, 1);
      cyc(0, 0, 0, 0, 0, 1); cyc(0, 0, 0, 0, 0, 0); cyc(0, 0, 0, 0, 0, 1);
      spot("play_en_after_serve", 4, 1);
      cyc(0, 0, 0, 0, 1, 0);
      spot("goal_p2_score", 2, 1);
      tick_n(2);
      spot("goal_hold", 0, 3);
      tick_n(1);
      spot("goal_to_serve", 0, 1);
      tick_n(2);
      cyc(0, 0, 0, 1, 1, 0);
      spot("double_goal_replay", 0, 1);
      tick_n(2);
      cyc(0, 0, 1, 0, 0, 0);
      spot("pause_entry", 0, 4);
      cyc(0, 0, 0, 1, 0, 1);
      spot("pause_ignores_goal", 1, 0);
      cyc(0, 0, 1, 0, 0, 0);
      spot("pause_exit", 0, 2);
      cyc(0, 0, 0, 1, 0, 0); tick_n(3); tick_n(2);
      cyc(0, 0, 0, 1, 0, 0); tick_n(3);
      spot("winner_p1", 3, 1);
      cyc(0, 1, 0, 0, 0, 0);
      spot("restart_clears", 1, 0);
      tick_n(2);
      cyc(0, 0, 0, 1, 0, 0); cyc(0, 0, 0, 0, 0, 1);
      cyc(1, 0, 0, 0, 0, 0);
      spot("reset_mid_goal", 5, 1);
      for (int i = 0; i < 4000; i++) begin
         cyc(($urandom_range(0, 199) == 0),
             ($urandom_range(0, 9) == 0),
             ($urandom_range(0, 14) == 0),
             ($urandom_range(0, 7) == 0),
             ($urandom_range(0, 7) == 0),
             ($urandom_range(0, 2) == 0));
      end
      cyc(0, 0, 0, 0, 0, 0);
      @(posedge clk); #3;
      stim_done = 1'b1;
   end

   initial begin
      fork
         wait (stim_done && exp_q.size() == 0);
         #500000;
      join_any
      disable fork;
      chk("scoreboard_drained", exp_q.size(), 0);
      chk("run_completed", int'(stim_done), 1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/game_sequencer.md
# game_sequencer

Match-level controller for the air hockey game. It sequences the puck/paddle datapath through idle, serve, play, goal-celebration, pause and game-over phases, and keeps both players' scores. Its state, scores and winner feed the VGA renderer and the seven-segment score display. It sits between the debounced button logic and the physics/collision datapath, gating motion with `play_en` and re-centring the puck with `puck_reset`.

## Interface
- `WIN_SCORE`, 7: score that ends the match; legal range 1..15.
- `SERVE_FRAMES`, 60: frame ticks the puck is held centred before play starts; legal range 1..255.
- `GOAL_FRAMES`, 120: frame ticks of freeze after a goal; legal range 1..255.

- `InputClock`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `frame_tick`  in  1  one-cycle pulse per video frame (vsync-derived).
- `start_pulse`  in  1  one-cycle debounced start/restart request.
- `pause_pulse`  in  1  one-cycle debounced pause toggle.
- `goal_p1`  in  1  one-cycle pulse: puck entered P2's goal, P1 scores.
- `goal_p2`  in  1  one-cycle pulse: puck entered P1's goal, P2 scores.
- `state`  out  3  0=IDLE, 1=SERVE, 2=PLAY, 3=GOAL, 4=PAUSE, 5=OVER.
- `play_en`  out  1  high only in PLAY; enables puck/paddle motion.
- `puck_reset`  out  1  high in IDLE and SERVE; datapath holds the puck at centre.
- `serve_dir`  out  1  0 = serve toward P1, 1 = toward P2.
- `score_p1`, `score_p2`  out  4 each  current scores, binary.
- `winner`  out  2  0 = none, 1 = P1, 2 = P2; nonzero only in OVER.

## Operation
- All outputs registered. Reset values: state=IDLE, play_en=0, puck_reset=1, serve_dir=0, scores=0, winner=0, frame counter=0.
- Frame counter: 8 bits; increments only on `frame_tick` in SERVE or GOAL; cleared on every state entry; frozen in PAUSE.
- IDLE: `start_pulse` -> SERVE. All other inputs ignored.
- SERVE: on the `frame_tick` where count == SERVE_FRAMES-1 -> PLAY. `goal_*` ignored.
- PLAY:
  - `goal_p1` alone: score_p1 += 1, serve_dir=1 -> GOAL.
  - `goal_p2` alone: score_p2 += 1, serve_dir=0 -> GOAL.
  - Both in the same cycle: no score change, serve_dir unchanged -> SERVE (replay).
  - `pause_pulse` -> PAUSE. A goal in the same cycle takes priority and the pause is dropped.
- PAUSE: play_en=0, puck_reset=0, puck frozen in place. `pause_pulse` -> PLAY. Goals and ticks ignored.
- GOAL: play_en=0. On the `frame_tick` where count == GOAL_FRAMES-1:
  - if either score == WIN_SCORE -> OVER, with winner set to that player;
  - otherwise -> SERVE.
- OVER: scores and winner held. `start_pulse` clears scores and winner, sets serve_dir=0 -> SERVE.
- `start_pulse` is ignored in SERVE, PLAY, GOAL and PAUSE. `pause_pulse` is ignored outside PLAY and PAUSE.
- Scores saturate at WIN_SCORE and never wrap; the GOAL exit makes overflow unreachable.
- `rst` asserted in any state, including mid-GOAL or PAUSE, returns everything to reset values on the next edge.

## Timing
- Inputs are sampled at edge N. The new state, scores and outputs are visible after edge N; latency is one cycle.
- SERVE lasts exactly SERVE_FRAMES ticks. GOAL lasts exactly GOAL_FRAMES ticks. Cycles without a tick do not advance either phase.
- A `frame_tick` coinciding with a state entry is not counted. Counting starts with the first tick after entry.
- `play_en` and `puck_reset` are never both high.
- `winner` changes in the same cycle that `state` becomes OVER.

## Test plan
Bench uses WIN_SCORE=2, SERVE_FRAMES=2, GOAL_FRAMES=3.
- Reset, then `start_pulse` -> state=1, puck_reset=1. After 2 `frame_tick`s -> state=2, play_en=1, puck_reset=0 one cycle after the 2nd tick.
- In PLAY, `goal_p2` -> score_p2=1, serve_dir=0, state=3. Ticks 1 and 2 keep state=3; tick 3 -> state=1.
- In PLAY, `goal_p1` and `goal_p2` in the same cycle -> scores unchanged, state=1.
- `pause_pulse` in PLAY -> state=4, play_en=0. `goal_p1` and ticks are ignored. `pause_pulse` -> state=2.
- P1 scores twice -> after the second GOAL phase, state=5, winner=1, score_p1=2. `start_pulse` -> scores 0, winner 0, state=1.
- `rst` asserted mid-GOAL (score_p1=1) -> next edge: state=0, scores 0, puck_reset=1.
